// File: rtl/button_debouncer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_debouncer_if
// Brief    : Raw button inputs and cleaned pulse/level outputs of the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface button_debouncer_if;
    logic left_raw;
    logic right_raw;
    logic fire_raw;
    logic left_debounced;
    logic right_debounced;
    logic fire_debounced;
    logic left_level;
    logic right_level;
    logic fire_level;

    modport master (
        output left_raw, right_raw, fire_raw,
        input  left_debounced, right_debounced, fire_debounced,
        input  left_level, right_level, fire_level
    );

    modport slave (
        input  left_raw, right_raw, fire_raw,
        output left_debounced, right_debounced, fire_debounced,
        output left_level, right_level, fire_level
    );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Two-flop sync, stability-count filter and press/auto-repeat pulse
//            generation for the left, right and fire buttons.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 850000,
    parameter int REPEAT_DELAY    = 34000000,
    parameter int REPEAT_RATE     = 12750000,
    parameter int CNT_W           = 26
) (
    input  logic               clk_85MHz,
    input  logic               reset,
    button_debouncer_if.slave  btn
);

    localparam int N_CH = 3;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    typedef enum logic {
        FIRE_IDLE = 1'b0,
        FIRE_HELD = 1'b1
    } fire_state_t;

    // Channel order throughout: bit 0 left, bit 1 right, bit 2 fire.
    logic [N_CH-1:0] raw_w;
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    wire  [N_CH-1:0] level_w;
    wire  [1:0]      pulse_w;
    logic            both_held_w;

    assign raw_w = {btn.fire_raw, btn.right_raw, btn.left_raw};

    always_ff @(posedge clk_85MHz) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             lvl_q;
        logic             lvl_d;

        // Any sample agreeing with the current level restarts the count.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (sync2_q[gi] != lvl_q) begin
                if (cnt_q == DB_LAST) begin
                    lvl_d = sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_85MHz) begin
            if (!reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level_w[gi] = lvl_q;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rep
        rep_state_t       state_q;
        rep_state_t       state_d;
        logic [CNT_W-1:0] rcnt_q;
        logic [CNT_W-1:0] rcnt_d;
        logic             pulse_q;
        logic             pulse_d;

        // Release has priority over a repeat falling due in the same cycle.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            pulse_d = 1'b0;
            case (state_q)
                REP_IDLE: begin
                    rcnt_d = '0;
                    if (level_w[gi]) begin
                        pulse_d = 1'b1;
                        state_d = REP_DELAY;
                    end
                end
                REP_DELAY: begin
                    if (!level_w[gi]) begin
                        rcnt_d  = '0;
                        state_d = REP_IDLE;
                    end else if (rcnt_q == RD_LAST) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = REP_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                REP_REPEAT: begin
                    if (!level_w[gi]) begin
                        rcnt_d  = '0;
                        state_d = REP_IDLE;
                    end else if (rcnt_q == RR_LAST) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    rcnt_d  = '0;
                    state_d = REP_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk_85MHz) begin
            if (!reset) begin
                state_q <= REP_IDLE;
                rcnt_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                pulse_q <= pulse_d;
            end
        end

        assign pulse_w[gi] = pulse_q;
    end

    fire_state_t fire_state_q;
    fire_state_t fire_state_d;
    logic        fire_pulse_q;
    logic        fire_pulse_d;

    always_comb begin
        fire_state_d = fire_state_q;
        fire_pulse_d = 1'b0;
        if (fire_state_q == FIRE_IDLE) begin
            if (level_w[2]) begin
                fire_pulse_d = 1'b1;
                fire_state_d = FIRE_HELD;
            end
        end else if (!level_w[2]) begin
            fire_state_d = FIRE_IDLE;
        end
    end

    always_ff @(posedge clk_85MHz) begin
        if (!reset) begin
            fire_state_q <= FIRE_IDLE;
            fire_pulse_q <= 1'b0;
        end else begin
            fire_state_q <= fire_state_d;
            fire_pulse_q <= fire_pulse_d;
        end
    end

    // Opposing directions held together: both FSMs keep counting, pulses are dropped.
    assign both_held_w = level_w[0] & level_w[1];

    assign btn.left_debounced  = pulse_w[0] & ~both_held_w;
    assign btn.right_debounced = pulse_w[1] & ~both_held_w;
    assign btn.fire_debounced  = fire_pulse_q;
    assign btn.left_level      = level_w[0];
    assign btn.right_level     = level_w[1];
    assign btn.fire_level      = level_w[2];

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Converts the raw, asynchronous cabinet push-buttons (left, right, fire) into clean, single-cycle command pulses in the clk_85MHz domain.
- Its left_debounced and right_debounced outputs drive the ship position block; fire_debounced drives the bullet launcher.
- Each channel has a two-flop synchroniser, a stability-count debounce filter and a pulse generator.
- Left and right auto-repeat while held; fire never repeats.

Parameters:
- DEBOUNCE_CYCLES, 850000, consecutive stable samples needed to accept a level change (10 ms at 85 MHz).
- REPEAT_DELAY, 34000000, cycles from the press pulse to the first auto-repeat pulse (400 ms).
- REPEAT_RATE, 12750000, cycles between subsequent auto-repeat pulses (150 ms).
- CNT_W, 26, width of all internal counters; must hold the largest of the three parameters.

Ports:
- clk_85MHz  input  1  system clock, 85 MHz
- reset  input  1  synchronous, active-low reset
- left_raw  input  1  raw left button, active-high, asynchronous, bouncing
- right_raw  input  1  raw right button, same
- fire_raw  input  1  raw fire button, same
- left_debounced  output  1  one-cycle pulse: left press or auto-repeat
- right_debounced  output  1  one-cycle pulse: right press or auto-repeat
- fire_debounced  output  1  one-cycle pulse: fire press only
- left_level, right_level, fire_level  output  1 each  filtered stable button level

Behaviour:
- Reset (reset==0 at a clk_85MHz edge):
  - All synchroniser flops, stable levels, counters and FSMs go to 0 / IDLE.
  - All six outputs are 0 the cycle after.
  - Reset dominates every other event, including mid-debounce and mid-repeat.
- Synchroniser: sync1 <= raw; sync2 <= sync1. There is no other path from raw to logic.
- Debounce filter, per channel, with stable level L and counter C:
  - If sync2 == L: C <= 0.
  - Else, if C == DEBOUNCE_CYCLES-1: L <= sync2 and C <= 0.
  - Otherwise: C <= C+1.
  - Any bounce back to L restarts the count. Press and release use the same rule.
- Latency: let edge k be the first edge where sync1 samples raw=1 and raw then stays high.
  - L rises at edge k+1+DEBOUNCE_CYCLES.
  - The press pulse is high during the cycle after edge k+2+DEBOUNCE_CYCLES.
  - Release latency to L falling is the same. Release produces no pulse.
- Pulse FSM for left and right, with repeat counter R:
  - IDLE:
    - On L rising: pulse 1 cycle, R <= 0, go to DELAY.
  - DELAY:
    - R increments each cycle.
    - When R == REPEAT_DELAY-1: pulse, R <= 0, go to REPEAT.
    - On L==0: go to IDLE, no pulse.
  - REPEAT:
    - R increments each cycle.
    - When R == REPEAT_RATE-1: pulse, R <= 0, stay in REPEAT.
    - On L==0: go to IDLE, no pulse.
  - Pulse spacing is therefore exactly REPEAT_DELAY cycles from the press pulse to the first repeat, then REPEAT_RATE cycles between repeats.
- Fire FSM: IDLE → pulse on L rising → HELD. HELD returns to IDLE on L==0. No repeat.
- Mutual exclusion:
  - While left_level and right_level are both 1, left_debounced and right_debounced are forced to 0.
  - Both FSMs keep running and counting; only the outputs are gated.
  - A pulse due in a gated cycle is lost, not deferred.
  - fire is independent of left and right.
- Pulse width is always exactly 1 cycle. No two pulses on one channel are ever adjacent.
- Button held through reset deassertion: treated as a new press, with a pulse after full debounce latency.

Test Plan (override DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3):
1. Clean press: left_raw 0→1 sampled at edge k, held → left_level rises at edge k+5; a single left_debounced pulse in the cycle after edge k+6. left_raw then 1→0 → no pulse; left_level falls 5 edges after sampling.
2. Bounce: fire_raw toggles 1,0,1,0 on alternating cycles then settles at 1 → no pulse until 4 consecutive high sync2 samples; exactly one fire_debounced pulse; holding 40 cycles gives no further pulse.
3. Auto-repeat: right held 40 cycles after the press pulse at cycle P → pulses at P, P+10, P+13, P+16, …; release mid-interval → no further pulse, FSM back to IDLE.
4. Simultaneous: left then right pressed so both levels are 1 → no left or right pulses while both are held; release right → left resumes repeat pulses from its running counter.
5. Reset mid-operation: reset=0 for 1 cycle during REPEAT with left held → all outputs 0; after reset, a new press pulse appears 6 edges later (full latency), then a repeat after 10.
6. Glitch rejection: a 3-cycle-wide raw pulse on each input → no level change, no pulses.
